// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM state type and sizing helpers for
//               the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
// Module      : muldiv_if
// Description : Request/response bundle between the register-file read ports,
//               the multiply/divide unit and the writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_if #(
    parameter int XLEN = muldiv_pkg::XLEN_DEF
);
    logic            Start;
    logic [2:0]      Op;
    logic [XLEN-1:0] Src_A;
    logic [XLEN-1:0] Src_B;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Rd_Data;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (
        output Start, Op, Src_A, Src_B,
        input  Busy, Done, Rd_Data, HI, LO
    );

    modport slave (
        input  Start, Op, Src_A, Src_B,
        output Busy, Done, Rd_Data, HI, LO
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_divider.sv
// ============================================================================
// Module      : muldiv_divider
// Description : Unsigned restoring divider, one quotient bit per step.
//               quotient/remainder show the values the current step produces.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_divider #(
    parameter int XLEN = 32
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    input  wire logic            load,
    input  wire logic            step,
    input  wire logic [XLEN-1:0] dividend,
    input  wire logic [XLEN-1:0] divisor,
    output logic      [XLEN-1:0] quotient,
    output logic      [XLEN-1:0] remainder
);
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    // r_quo starts as the dividend and shifts quotient bits in from the right
    assign w_trial   = {r_rem, r_quo[XLEN-1]};
    assign w_ge      = (w_trial >= {1'b0, r_dvs});
    assign w_diff    = w_trial[XLEN-1:0] - r_dvs;
    assign remainder = w_ge ? w_diff : w_trial[XLEN-1:0];
    assign quotient  = {r_quo[XLEN-2:0], w_ge};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
        end else if (step) begin
            r_rem <= remainder;
            r_quo <= quotient;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//               Define MULDIV_DIV_EN to build the divider and DIV/DIVU support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  wire logic CLK,
    input  wire logic RST,
    muldiv_if.slave   bus
);
    localparam int              c_cnt_w = cnt_width(XLEN);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_rd;

    logic [2*XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]    r_mplier;
    logic [2*XLEN-1:0]  r_acc;
    logic               r_neg;
    logic [2*XLEN-1:0]  w_acc_nxt;
    logic [2*XLEN-1:0]  w_prod;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic               w_is_mul;

    // Op[0] marks the signed variant of both MULT and DIV
    assign w_signed = bus.Op[0];
    assign w_a_neg  = w_signed & bus.Src_A[XLEN-1];
    assign w_b_neg  = w_signed & bus.Src_B[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~bus.Src_A + 1'b1) : bus.Src_A;
    assign w_b_mag  = w_b_neg ? (~bus.Src_B + 1'b1) : bus.Src_B;
    assign w_is_mul = (bus.Op == OP_MULTU) || (bus.Op == OP_MULT);

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod    = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

`ifdef MULDIV_DIV_EN
    logic               w_is_div;
    logic               r_rneg;
    logic               r_dz;
    logic [XLEN-1:0]    r_a_raw;
    logic [XLEN-1:0]    w_q_mag;
    logic [XLEN-1:0]    w_r_mag;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;

    assign w_is_div = (bus.Op == OP_DIVU) || (bus.Op == OP_DIV);

    muldiv_divider #(
        .XLEN      (XLEN)
    ) u_divider (
        .CLK       (CLK),
        .RST       (RST),
        .load      (w_accept && w_is_div),
        .step      (r_state == DIV),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .quotient  (w_q_mag),
        .remainder (w_r_mag)
    );

    // Most-negative / -1 falls out naturally: magnitude quotient wraps to MIN
    assign w_quo = r_dz ? '1 : (r_neg ? (~w_q_mag + 1'b1) : w_q_mag);
    assign w_rem = r_dz ? r_a_raw : (r_rneg ? (~w_r_mag + 1'b1) : w_r_mag);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_accept = 1'b1;
                    if (w_is_mul) begin
                        w_state_nxt = MUL;
                    end
`ifdef MULDIV_DIV_EN
                    else if (w_is_div) begin
                        w_state_nxt = DIV;
                    end
`endif
                end
            end
            MUL, DIV: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_rd     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
            r_a_raw  <= '0;
`endif
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= 1'b0;
            if (w_accept) begin
                // Single-cycle ops (including disabled divides) complete now
                r_done <= (w_state_nxt == IDLE);
                r_cnt  <= '0;
                case (bus.Op)
                    OP_MFHI: r_rd <= r_hi;
                    OP_MFLO: r_rd <= r_lo;
                    OP_MTHI: r_hi <= bus.Src_A;
                    OP_MTLO: r_lo <= bus.Src_A;
                    OP_MULTU, OP_MULT: begin
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_neg    <= w_a_neg ^ w_b_neg;
                    end
`ifdef MULDIV_DIV_EN
                    OP_DIVU, OP_DIV: begin
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_rneg  <= w_a_neg;
                        r_dz    <= (bus.Src_B == '0);
                        r_a_raw <= bus.Src_A;
                    end
`endif
                    default: ;
                endcase
            end else if (r_state == MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    {r_hi, r_lo} <= w_prod;
                    r_done       <= 1'b1;
                    r_cnt        <= '0;
                end
            end
`ifdef MULDIV_DIV_EN
            else if (r_state == DIV) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    r_lo   <= w_quo;
                    r_hi   <= w_rem;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end
            end
`endif
        end
    end

    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.Rd_Data = r_rd;
    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;

endmodule

`default_nettype wire
